aes_key_expand: RTL

//  Iterative AES key expansion per FIPS-197 for AES-128/192/256, selected by parameter.
//  - Produces one 32-bit schedule word per cycle.
//  - Packs every 4 words into a 128-bit round key and streams the Nr+1 round keys out.
//  - Uses a valid/ready handshake with full backpressure.
//  - SubWord uses four shared S-boxes outside the block, connected through sbox_o/sbox_i
//    (combinational, same cycle). Sits between the key register and the round datapath.

---
 rtl/aes_key_expand.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128/192/256 key schedule.
// One schedule word is produced per cycle from an NK-word sliding window.
// Every group of four words is packed into a 128-bit round key and streamed out
// over a valid/ready handshake with full backpressure. SubWord is done by four
// S-boxes outside this block, reached combinationally through sbox_o/sbox_i.
module aes_key_expand #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [KEY_BITS-1:0] key_i,
  input  logic [31:0]         sbox_i,
  output logic [31:0]         sbox_o,
  output logic [127:0]        rk_o,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [3:0]          rk_idx,
  output logic                rk_last,
  output logic                busy,
  output logic                done
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  // Only the three FIPS-197 key lengths are meaningful.
  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_key_expand: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  // Window: win[0] = w[i-NK] ... win[NK-1] = w[i-1].
  // While i < NK the window simply rotates, so win[0] is always key word i and
  // after NK rotations the window holds w[0..NK-1] again.
  logic [31:0] win [NK];
  logic [31:0] key_word [NK];
  logic [31:0] hold [3];      // first three words of the round key being assembled
  logic [5:0]  i;             // index of the next word to produce
  logic [2:0]  k;             // i mod NK
  logic [7:0]  rcon;

  logic        load;
  logic        xfer;
  logic        last_xfer;
  logic        gen_en;
  logic        rk_load;
  logic [31:0] new_w;

  // Key word n is taken most-significant first.
  genvar gi;
  generate
    for (gi = 0; gi < NK; gi++) begin : g_key_word
      assign key_word[gi] = key_i[KEY_BITS-1-32*gi -: 32];
    end
  endgenerate

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Handshake and generation enables; the 4th word of a group waits while a key is stuck.
  always_comb begin
    xfer      = rk_valid && rk_ready;
    last_xfer = (state == EXPAND) && xfer && rk_last;
    gen_en    = (state == EXPAND) && (i < 6'(NW)) &&
                !(rk_valid && !rk_ready && (i[1:0] == 2'd3));
    rk_load   = gen_en && (i[1:0] == 2'd3);
  end

  // S-box request: rotated previous word at the start of each NK group, else plain previous word.
  always_comb begin
    sbox_o = (k == 3'd0) ? {win[NK-1][23:0], win[NK-1][31:24]} : win[NK-1];
  end

  // Next schedule word.
  always_comb begin
    new_w = win[0];
    if (i >= 6'(NK)) begin
      if (k == 3'd0) begin
        new_w = win[0] ^ sbox_i ^ {rcon, 24'h0};
      end else if (NK == 8 && k == 3'd4) begin
        new_w = win[0] ^ sbox_i;
      end else begin
        new_w = win[0] ^ win[NK-1];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state; abort overrides everything, start only counts from IDLE/DONE.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = EXPAND;
          load       = 1'b1;
        end
      end
      EXPAND: begin
        if (last_xfer) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      load       = 1'b0;
    end
  end

  // Window, word counters and rcon.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NK; n++) win[n] <= '0;
      i    <= '0;
      k    <= '0;
      rcon <= 8'h01;
    end else if (abort) begin
      for (int n = 0; n < NK; n++) win[n] <= '0;
      i    <= '0;
      k    <= '0;
      rcon <= 8'h01;
    end else if (load) begin
      for (int n = 0; n < NK; n++) win[n] <= key_word[n];
      i    <= '0;
      k    <= '0;
      rcon <= 8'h01;
    end else if (gen_en) begin
      for (int n = 0; n < NK - 1; n++) win[n] <= win[n+1];
      win[NK-1] <= new_w;
      i <= i + 6'd1;
      k <= (k == 3'(NK - 1)) ? 3'd0 : k + 3'd1;
      if (i >= 6'(NK) && k == 3'd0) begin
        rcon <= xtime(rcon);
      end
    end
  end

  // Buffer the first three words of each round key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 3; n++) hold[n] <= '0;
    end else if (abort) begin
      for (int n = 0; n < 3; n++) hold[n] <= '0;
    end else if (gen_en && (i[1:0] != 2'd3)) begin
      hold[i[1:0]] <= new_w;
    end
  end

  // Round-key output register; a new key may replace one transferring on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_o     <= '0;
      rk_valid <= 1'b0;
      rk_idx   <= '0;
      rk_last  <= 1'b0;
    end else if (abort) begin
      rk_o     <= '0;
      rk_valid <= 1'b0;
      rk_idx   <= '0;
      rk_last  <= 1'b0;
    end else if (load) begin
      rk_valid <= 1'b0;
    end else if (rk_load) begin
      rk_o     <= {hold[0], hold[1], hold[2], new_w};
      rk_valid <= 1'b1;
      rk_idx   <= i[5:2];
      rk_last  <= (i[5:2] == 4'(NR));
    end else if (xfer) begin
      rk_valid <= 1'b0;
    end
  end

  // Status flags: busy mirrors EXPAND, done pulses after the final transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == EXPAND);
      done <= last_xfer && !abort;
    end
  end

endmodule
